// File: rtl/raid_pkg.sv
// Shared types and disk-placement helpers for the RAID-5 stripe write stage.
package raid_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE} state_t;

  function automatic int unsigned parity_disk(input int unsigned addr, input int unsigned n);
    return addr % n;
  endfunction

  // Data codewords skip over the parity slot of the stripe.
  function automatic int unsigned data_to_disk(input int unsigned j, input int unsigned p);
    return (j < p) ? j : j + 1;
  endfunction

endpackage

// File: rtl/raid_stripe_map.sv
// Rotating-parity placement: maps need mask, parity slot and codewords onto per-disk lanes.
module raid_stripe_map
  import raid_pkg::*;
#(
    parameter int unsigned N_DISKS = 3,
    parameter int unsigned DATA_W  = 12
) (
    input  logic [N_DISKS-2:0]            need,
    input  logic [$clog2(N_DISKS)-1:0]    p,
    input  logic [DATA_W-1:0]             parity,
    input  logic [(N_DISKS-1)*DATA_W-1:0] data_enc,
    output logic [N_DISKS-1:0]            wr_en,
    output logic [N_DISKS*DATA_W-1:0]     wr_disk
);

    always_comb begin
        int unsigned pd;
        pd      = 32'(p);
        wr_en   = '0;
        wr_disk = '0;
        if (|need) begin
            for (int unsigned k = 0; k < N_DISKS; k++) begin
                if (k == pd) begin
                    wr_en[k]                     = 1'b1;
                    wr_disk[k*DATA_W +: DATA_W]  = parity;
                end
                for (int unsigned j = 0; j < N_DISKS - 1; j++) begin
                    if (need[j] && data_to_disk(j, pd) == k) begin
                        wr_en[k]                    = 1'b1;
                        wr_disk[k*DATA_W +: DATA_W] = data_enc[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/raid_stripe_writer.sv
// RAID-5 stripe write stage: captures a request, issues the stripe write and
// retries on missing ack, finishing every request with a done/err pulse.
module raid_stripe_writer
  import raid_pkg::*;
#(
    parameter int unsigned N_DISKS     = 3,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             wr_add,
    input  logic [DATA_W-1:0]             parity,
    input  logic [(N_DISKS-1)*DATA_W-1:0] data_enc,
    input  logic [N_DISKS-2:0]            synd_nz,
    input  logic [N_DISKS-2:0]            equal,
    input  logic                          mem_ack,
    output logic [N_DISKS*DATA_W-1:0]     wr_disk,
    output logic [N_DISKS-1:0]            wr_en,
    output logic                          wr_valid,
    output logic [ADDR_W-1:0]             address,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned PW = $clog2(N_DISKS);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t                          state, state_nxt;
    logic                            pend;
    logic                            accept;
    logic                            err_nxt;
    logic [TW-1:0]                   timer;
    logic [RW-1:0]                   retries;
    logic [ADDR_W-1:0]               addr_q;
    logic [DATA_W-1:0]               par_q;
    logic [(N_DISKS-1)*DATA_W-1:0]   data_q;
    logic [N_DISKS-2:0]              need_q;
    logic [PW-1:0]                   p_q;
    logic [N_DISKS-1:0]              map_en;
    logic [N_DISKS*DATA_W-1:0]       map_disk;

    assign accept = (state == IDLE) && !pend && start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            par_q  <= '0;
            data_q <= '0;
            need_q <= '0;
            p_q    <= '0;
        end else if (accept) begin
            addr_q <= wr_add;
            par_q  <= parity;
            data_q <= data_enc;
            need_q <= synd_nz | ~equal;
            p_q    <= PW'(parity_disk(32'(wr_add), N_DISKS));
        end
    end

    // The IDLE cycle after acceptance decides write vs no-write from the captured mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pend    <= 1'b0;
            timer   <= '0;
            retries <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == DONE);
            err   <= err_nxt;
            if (accept)                 pend <= 1'b1;
            else if (state_nxt != IDLE) pend <= 1'b0;
            if (state == ISSUE)         timer <= '0;
            else if (state == WAIT)     timer <= timer + 1'b1;
            if (accept)                 retries <= '0;
            else if (state == GAP)      retries <= retries + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE:  if (pend) state_nxt = (|need_q) ? ISSUE : DONE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                    if (retries < RW'(MAX_RETRY)) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            GAP:     state_nxt = ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_valid = 1'b0;
        wr_en    = '0;
        wr_disk  = '0;
        address  = '0;
        busy     = pend | (state != IDLE);
        unique case (state)
            ISSUE, WAIT: begin
                wr_valid = 1'b1;
                wr_en    = map_en;
                wr_disk  = map_disk;
                address  = addr_q;
            end
            GAP, DONE: address = addr_q;
            default: ;
        endcase
    end

    raid_stripe_map #(
        .N_DISKS(N_DISKS),
        .DATA_W (DATA_W)
    ) u_map (
        .need    (need_q),
        .p       (p_q),
        .parity  (par_q),
        .data_enc(data_q),
        .wr_en   (map_en),
        .wr_disk (map_disk)
    );

endmodule
